// File: rtl/prbs_pkg.sv
`default_nettype none
// prbs_pkg: default 15-stage PRBS constants and the multi-step LFSR keystream function.
// Rev 1.0
package prbs_pkg;

  localparam int          LFSR_W_MAX   = 32;
  localparam int          W_MAX        = 32;
  localparam logic [14:0] DEFAULT_TAPS = 15'h0003;  // 1 + x^14 + x^15
  localparam logic [14:0] DEFAULT_SEED = 15'h3715;

  typedef struct packed {
    logic [W_MAX-1:0]      ks;
    logic [LFSR_W_MAX-1:0] nxt;
  } step_t;

  // Keystream bit i is the MSB after i shifts; the loop bound is fixed so it
  // unrolls at elaboration, with steps beyond w left inert.
  function automatic step_t lfsr_advance(
    input logic [LFSR_W_MAX-1:0] state,
    input logic [LFSR_W_MAX-1:0] taps,
    input int                    lfsr_w,
    input int                    w
  );
    step_t                 r;
    logic [LFSR_W_MAX-1:0] s;
    logic                  fb;
    r = '0;
    s = state;
    for (int i = 0; i < W_MAX; i++) begin
      if (i < w) begin
        r.ks[i] = s[lfsr_w-1];
        fb      = ^(s & taps);
        s       = (s >> 1) | ({{(LFSR_W_MAX-1){1'b0}}, fb} << (lfsr_w - 1));
      end
    end
    r.nxt = s;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_lfsr_step.sv
`default_nettype none
// prbs_lfsr_step: combinational W-step LFSR advance producing the keystream for one beat.
// Rev 1.0
module prbs_lfsr_step
  import prbs_pkg::*;
#(
  parameter int                LFSR_W = 15,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
  parameter int                W      = 8
) (
  input  logic [LFSR_W-1:0] state,
  output logic [W-1:0]      keystream,
  output logic [LFSR_W-1:0] next_state
);

  step_t r;
  logic  unused_step_bits;

  always_comb begin
    r          = lfsr_advance(LFSR_W_MAX'(state), LFSR_W_MAX'(TAPS), LFSR_W, W);
    keystream  = r.ks[W-1:0];
    next_state = r.nxt[LFSR_W-1:0];
  end

  assign unused_step_bits = ^r;

endmodule
`default_nettype wire

// File: rtl/prbs_randomizer_stream.sv
`default_nettype none
// prbs_randomizer_stream: additive LFSR (de)randomizer on a valid/ready stream with per-block reseed.
// Rev 1.0
module prbs_randomizer_stream
  import prbs_pkg::*;
#(
  parameter int                LFSR_W      = 15,
  parameter logic [LFSR_W-1:0] TAPS        = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0] SEED        = LFSR_W'(DEFAULT_SEED),
  parameter int                W           = 8,
  parameter int                BLOCK_BEATS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              bypass,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  output logic [15:0]       blk_beat_cnt
);

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] seed_reg;
  logic [LFSR_W-1:0] next_state;
  logic [LFSR_W-1:0] seed_eff;
  logic [W-1:0]      keystream;
  logic              accept;
  logic              blk_end;

  prbs_lfsr_step #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .W      (W)
  ) u_step (
    .state      (state),
    .keystream  (keystream),
    .next_state (next_state)
  );

  assign in_ready = reset && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  // An all-zero seed would lock the LFSR, so it falls back to the default.
  assign seed_eff = (seed_in == '0) ? SEED : seed_in;
  assign blk_end  = in_last ||
                    ((BLOCK_BEATS != 0) && (({1'b0, blk_beat_cnt} + 17'd1) == 17'(BLOCK_BEATS)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SEED;
      seed_reg     <= SEED;
      blk_beat_cnt <= '0;
    end else if (seed_load) begin
      state        <= seed_eff;
      seed_reg     <= seed_eff;
      blk_beat_cnt <= '0;
    end else if (accept) begin
      if (blk_end) begin
        state        <= seed_reg;
        blk_beat_cnt <= '0;
      end else begin
        state <= next_state;
        if (blk_beat_cnt != 16'hFFFF) begin
          blk_beat_cnt <= blk_beat_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= bypass ? in_data : (in_data ^ keystream);
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
